profiler_readout: RTL and testbench
===================================

# profiler_readout

Snapshot-and-stream reader for the instruction profiler's ten 32-bit event counters. On a request pulse it latches all counters in the same cycle and emits one framed byte stream over a valid/ready byte link toward the host transmitter (UART/debug bridge). The frame carries a sync byte, a sequence/overrun byte, the little-endian counter payload and an optional XOR checksum.

## Interface
Parameters:
- NUM_COUNTERS, 10, number of 32-bit counters in the snapshot.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- snap_req  in  1  snapshot request; sampled every cycle.
- counters  in  NUM_COUNTERS*32  flat counter bus. Counter i occupies [32i+31:32i].
  - Counter order 0..9: load, store, add, bitwise, shift/rotate, comparison, branch, control-transfer, system/privilege, atomic.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last byte transfers.

## Operation
- FSM states:
  - IDLE: busy=0, tx_valid=0.
  - SYNC: tx_data=SYNC_BYTE.
  - SEQ: tx_data={ovr_pending, seq[6:0]}.
  - PAYLOAD: byte index b = 0..4*NUM_COUNTERS-1. tx_data = byte b[1:0] of shadow counter b>>2, LSB byte first.
  - CSUM: tx_data = XOR of the SEQ byte and every payload byte. SYNC is excluded.
- Transitions:
  - IDLE to SYNC when snap_req=1. In that same edge all counters are copied into the shadow registers and the checksum accumulator is cleared.
  - Each state advances only on transfer (tx_valid & tx_ready).
  - Last payload byte goes to CSUM. CSUM goes to IDLE.
- Shadow registers are never updated while busy. Counter changes during a frame do not affect that frame.
- seq is a 7-bit frame counter. It increments on CSUM transfer and wraps 0x7F to 0x00.
- Overrun handling:
  - ovr_pending sets when snap_req=1 while not in IDLE; such requests are otherwise ignored.
  - It clears on the SEQ byte transfer that carries it.
  - If a new overrun coincides with that transfer, set wins.
- Handshake: once tx_valid rises, tx_data holds stable and tx_valid stays high until transfer. No byte is dropped or duplicated.
- Reset values: tx_data=0x00, tx_valid=0, busy=0, frame_done=0, seq=0, ovr_pending=0, shadow registers=0, state=IDLE.
- Reset mid-frame aborts immediately. No partial frame completes and there is no frame_done.

## Timing
- snap_req high at edge k puts tx_valid=1 with SYNC from cycle k+1, and busy=1 from cycle k+1.
- With tx_ready held high, one byte transfers per cycle. A frame is 43 bytes = 43 cycles for NUM_COUNTERS=10 (42 without checksum).
- After the final transfer at edge m, cycle m+1 has busy=0, tx_valid=0 and frame_done=1 for exactly one cycle.
- snap_req in cycle m+1 is accepted (IDLE), giving a minimum inter-frame gap of 1 cycle.
- Stall cycles (tx_ready=0) extend latency one-for-one.
- rst_n assertion forces outputs to reset values asynchronously. Release is synchronised to clk by the integrating level.

## Configuration
- PROFILER_READOUT_CSUM_EN defined: the CSUM state and checksum accumulator exist, and frames are 3+4*NUM_COUNTERS bytes.
- Macro undefined: no checksum logic. The last payload transfer goes straight to IDLE, seq increments on that transfer, and frames are 2+4*NUM_COUNTERS bytes.

## Test plan
- Reset/idle: with rst_n low, then high with no snap_req, all outputs sit at reset values for 20 cycles and tx_valid never rises.
- Basic frame: counter0=0x12345678, others 0, one snap_req pulse, tx_ready=1.
  - Bytes: A5, 00, 78, 56, 34, 12, 36×00, 08.
  - 43 consecutive transfers, then frame_done for one cycle.
- Snapshot isolation: counter6 increments every cycle during the frame. Payload bytes 24-27 equal the counter6 value at request time.
- Backpressure: tx_ready random at 30% high. tx_data stays stable while tx_valid & !tx_ready, and the received byte sequence is identical to the basic frame.
- Overrun/sequence:
  - snap_req pulsed mid-frame is ignored.
  - The next frame's SEQ byte is 0x81 and its checksum includes 0x81.
  - After 128 total frames the seq field wraps to 0x00.
- Abort: rst_n driven low during payload byte 10 gives tx_valid=0 immediately. The next frame after release starts A5, 00.

Source files
------------

// File: rtl/profiler_readout.sv
// Snapshot-and-stream reader: latches the profiler counters on request and streams
// SYNC, SEQ, payload (and, with PROFILER_READOUT_CSUM_EN defined, an XOR checksum) bytes.
module profiler_readout #(
  parameter int          NUM_COUNTERS = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         snap_req,
  input  logic [NUM_COUNTERS*32-1:0]   counters,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int NB = 4 * NUM_COUNTERS;
  localparam int BW = $clog2(NB);

  // Handshake: tx_data is a register loaded only when a new byte is presented, so it
  // holds stable while tx_valid & !tx_ready; a byte moves on tx_valid & tx_ready.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_PAYLOAD
`ifdef PROFILER_READOUT_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_COUNTERS*32-1:0]   shadow_q, shadow_d;
  logic [BW-1:0]                byte_idx_q, byte_idx_d;
  logic [BW-1:0]                byte_nxt;
  logic [6:0]                   seq_q, seq_d;
  logic                         ovr_q, ovr_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         frame_done_q, frame_done_d;
  logic                         xfer;
  logic                         ovr_set;
  logic                         last_byte;
`ifdef PROFILER_READOUT_CSUM_EN
  logic [7:0]                   csum_q, csum_d;
`endif

  assign tx_valid   = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx_data    = tx_data_q;
  assign frame_done = frame_done_q;

  assign xfer      = tx_valid & tx_ready;
  assign ovr_set   = snap_req & (state_q != S_IDLE);
  assign last_byte = (byte_idx_q == BW'(NB - 1));
  assign byte_nxt  = byte_idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    byte_idx_d   = byte_idx_q;
    seq_d        = seq_q;
    ovr_d        = ovr_q;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
`ifdef PROFILER_READOUT_CSUM_EN
    csum_d       = csum_q;
`endif
    if (ovr_set) ovr_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          state_d   = S_SYNC;
          shadow_d  = counters;
          tx_data_d = SYNC_BYTE;
`ifdef PROFILER_READOUT_CSUM_EN
          csum_d    = 8'h00;
`endif
        end
      end
      S_SYNC: begin
        if (xfer) begin
          // The SEQ byte is frozen here; the overrun it carries is consumed now so a
          // request arriving while SEQ is stalled is kept for the next frame.
          state_d   = S_SEQ;
          tx_data_d = {ovr_q | ovr_set, seq_q};
          ovr_d     = 1'b0;
        end
      end
      S_SEQ: begin
        if (xfer) begin
          state_d    = S_PAYLOAD;
          byte_idx_d = '0;
          tx_data_d  = shadow_q[7:0];
`ifdef PROFILER_READOUT_CSUM_EN
          csum_d     = csum_q ^ tx_data_q;
`endif
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
`ifdef PROFILER_READOUT_CSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (last_byte) begin
`ifdef PROFILER_READOUT_CSUM_EN
            state_d   = S_CSUM;
            tx_data_d = csum_q ^ tx_data_q;
`else
            state_d      = S_IDLE;
            tx_data_d    = 8'h00;
            seq_d        = seq_q + 7'd1;
            frame_done_d = 1'b1;
`endif
          end else begin
            byte_idx_d = byte_nxt;
            tx_data_d  = 8'(shadow_q >> {byte_nxt, 3'b000});
          end
        end
      end
`ifdef PROFILER_READOUT_CSUM_EN
      S_CSUM: begin
        if (xfer) begin
          state_d      = S_IDLE;
          tx_data_d    = 8'h00;
          seq_d        = seq_q + 7'd1;
          frame_done_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      byte_idx_q   <= '0;
      seq_q        <= 7'd0;
      ovr_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef PROFILER_READOUT_CSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      byte_idx_q   <= byte_idx_d;
      seq_q        <= seq_d;
      ovr_q        <= ovr_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
`ifdef PROFILER_READOUT_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_profiler_readout.sv
// Self-checking bench for profiler_readout: random stimulus against a frame-level
// reference model (byte list built from the snapshot, sequence count and overrun flag).
module tb_profiler_readout;

  localparam int NC = 10;
`ifdef PROFILER_READOUT_CSUM_EN
  localparam int FLEN = 3 + 4 * NC;
`else
  localparam int FLEN = 2 + 4 * NC;
`endif
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              snap_req = 1'b0;
  logic              tx_ready = 1'b0;
  logic [NC*32-1:0]  counters;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              busy;
  logic              frame_done;

  int unsigned       cnt[NC];
  int                n_checks = 0;
  int                n_fail = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        got_q[$];
  logic [7:0]        basic_q[$];
  int                seq_m = 0;
  bit                ovr_m = 1'b0;
  int                frames = 0;
  int                cyc = 0;
  int unsigned       snap6;

  profiler_readout #(.NUM_COUNTERS(NC), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snap_req   (snap_req),
    .counters   (counters),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- clock / counter bus ----------------
  always #5 clk = ~clk;

  always_comb begin
    counters = '0;
    for (int i = 0; i < NC; i++) counters[i*32 +: 32] = cnt[i];
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_exp(input int unsigned snap[NC]);
    logic [7:0] sb;
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    sb = {ovr_m, 7'(seq_m % 128)};
    exp_q.push_back(sb);
    cs = sb;
    for (int i = 0; i < NC; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'((snap[i] >> (8 * j)) & 32'hFF);
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef PROFILER_READOUT_CSUM_EN
    exp_q.push_back(cs);
`endif
    ovr_m = 1'b0;
    seq_m = (seq_m + 1) % 128;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_request();
    snap_req = 1'b1;
    build_exp(cnt);
    @(negedge clk);
    snap_req = 1'b0;
    check_eq("busy_after_req", busy, 1'b1);
  endtask

  task automatic recv_frame(input int ready_pct, input bit bump_c6, input int ovr_at,
                            input int stop_at);
    bit         stalled = 1'b0;
    bit         pulsed = 1'b0;
    logic [7:0] held = 8'h00;
    bit         rdy;
    got_q.delete();
    cyc = 0;
    while (got_q.size() < exp_q.size() && got_q.size() < stop_at && cyc < BUDGET) begin
      snap_req = 1'b0;
      check_eq("valid_in_frame", tx_valid, 1'b1);
      if (stalled) check_eq("data_stable", tx_data, held);
      rdy = ($urandom_range(0, 99) < ready_pct);
      tx_ready = rdy;
      if (rdy) got_q.push_back(tx_data);
      stalled = !rdy;
      held = tx_data;
      if (!pulsed && ovr_at >= 0 && got_q.size() == ovr_at) begin
        snap_req = 1'b1;
        ovr_m = 1'b1;
        pulsed = 1'b1;
      end
      if (bump_c6) cnt[6] = cnt[6] + 1;
      @(negedge clk);
      cyc++;
    end
    snap_req = 1'b0;
    tx_ready = 1'b0;
    if (cyc >= BUDGET) check_eq("recv_budget", cyc, 0);
  endtask

  task automatic finish_frame();
    check_eq("done_pulse", frame_done, 1'b1);
    check_eq("busy_end", busy, 1'b0);
    check_eq("valid_end", tx_valid, 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", frame_done, 1'b0);
    check_eq("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("byte%0d", i), got_q[i], exp_q[i]);
    frames++;
  endtask

  task automatic randomize_counters();
    for (int i = 0; i < NC; i++) cnt[i] = $urandom();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", tx_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_data", tx_data, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_valid", tx_valid, 1'b0);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_done", frame_done, 1'b0);
      check_eq("idle_data", tx_data, 8'h00);
    end

    // Basic frame, with an ignored mid-frame request that must flag the next SEQ byte.
    cnt[0] = 32'h1234_5678;
    do_request();
    recv_frame(100, 1'b0, 20, FLEN);
    check_eq("basic_cycles", cyc, FLEN);
    finish_frame();
    check_eq("basic_b0", got_q[0], 8'hA5);
    check_eq("basic_b1", got_q[1], 8'h00);
    check_eq("basic_b2", got_q[2], 8'h78);
    check_eq("basic_b3", got_q[3], 8'h56);
    check_eq("basic_b4", got_q[4], 8'h34);
    check_eq("basic_b5", got_q[5], 8'h12);
`ifdef PROFILER_READOUT_CSUM_EN
    check_eq("basic_csum", got_q[FLEN-1], 8'h08);
`endif
    basic_q = got_q;

    do_request();
    recv_frame(100, 1'b0, -1, FLEN);
    finish_frame();
    check_eq("ovr_seq", got_q[1], 8'h81);

    // Snapshot isolation: counter 6 keeps counting while the frame streams.
    randomize_counters();
    snap6 = cnt[6];
    do_request();
    recv_frame(100, 1'b1, -1, FLEN);
    finish_frame();
    for (int j = 0; j < 4; j++)
      check_eq($sformatf("iso_b%0d", 24 + j), got_q[2+24+j], 8'((snap6 >> (8 * j)) & 32'hFF));

    // Backpressure: same counters as the basic frame, sink ready 30% of cycles.
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    cnt[0] = 32'h1234_5678;
    do_request();
    recv_frame(30, 1'b0, -1, FLEN);
    finish_frame();
    for (int i = 2; i < 2 + 4 * NC && i < got_q.size(); i++)
      check_eq($sformatf("bp_payload%0d", i), got_q[i], basic_q[i]);

    // Random frames until 128 have completed; frame 129 must carry seq 0.
    while (frames < 128) begin
      randomize_counters();
      do_request();
      recv_frame($urandom_range(0, 1) ? 100 : 60, 1'b0, -1, FLEN);
      finish_frame();
    end
    randomize_counters();
    do_request();
    recv_frame(100, 1'b0, -1, FLEN);
    finish_frame();
    check_eq("seq_wrap", got_q[1], 8'h00);

    // Abort: reset while payload byte 10 is presented.
    randomize_counters();
    do_request();
    recv_frame(100, 1'b0, -1, 12);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", tx_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_data", tx_data, 8'h00);
    repeat (2) @(negedge clk);
    check_eq("abort_no_done", frame_done, 1'b0);
    rst_n = 1'b1;
    seq_m = 0;
    ovr_m = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", tx_valid, 1'b0);
    randomize_counters();
    do_request();
    recv_frame(100, 1'b0, -1, FLEN);
    finish_frame();
    check_eq("post_abort_b0", got_q[0], 8'hA5);
    check_eq("post_abort_b1", got_q[1], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
